fetch_unit: RTL

//   Instruction fetch stage directly upstream of the controller: owns the fetch

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and memory.
//   mem_req  : read request, held until mem_ack
//   mem_addr : read address, stable while mem_req=1
//   mem_ack  : read complete, mem_data valid in the same cycle
//   mem_data : read data
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch pointer, prefetches from instruction
// memory over a req/ack channel into a small FIFO and hands one instruction to
// the controller per fetch pulse. Jumps flush the stream and redirect it.
//   clk, rst     : clock, asynchronous active-high reset
//   fetch        : controller request for the next instruction (1-cycle pulse)
//   jmp/jmp_addr : redirect pulse and target
//   mem          : memory read channel (master side)
//   instr/pc     : current instruction and its address (registered)
//   instr_valid  : instr holds a valid instruction
module fetch_unit #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    fetch_unit_if.master      mem,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BUF_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    entry_t            fifo_q [BUF_DEPTH];
    entry_t            head;
    logic              xfer;
    logic              take_fetch;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign xfer       = mem_req_q & mem.mem_ack;
    assign take_fetch = fetch & ~pend_q;
    assign head       = fifo_q[rd_ptr_q];

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        tgt_d      = tgt_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;
        count_nxt  = count_q;

        case (state_q)
            ST_RUN: begin
                if (jmp) begin
                    // Flush; a fetch on this edge is served from the target.
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    valid_d  = 1'b0;
                    pend_d   = pend_q | fetch;
                    if (mem_req_q && !mem.mem_ack) begin
                        state_d = ST_DRAIN;
                        tgt_d   = jmp_addr;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = jmp_addr;
                    end
                end else begin
                    // A waiting request, or a fetch landing on an empty FIFO
                    // together with a transfer, takes the read data directly.
                    if (xfer && (pend_q || (take_fetch && count_q == '0))) begin
                        instr_d = mem.mem_data;
                        pc_d    = mem_addr_q;
                        valid_d = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        push = xfer;
                        if (take_fetch && count_q != '0) begin
                            pop     = 1'b1;
                            instr_d = head.data;
                            pc_d    = head.addr;
                            valid_d = 1'b1;
                        end else if (take_fetch) begin
                            valid_d = 1'b0;
                            pend_d  = 1'b1;
                        end
                    end

                    count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
                    count_d   = count_nxt;
                    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
                    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
                    if (xfer) mem_addr_d = mem_addr_q + ADDR_W'(1);
                    // Request state may only change at a transfer or when idle.
                    if (xfer || !mem_req_q) mem_req_d = (count_nxt < CNT_FULL);
                end
            end

            ST_DRAIN: begin
                // FIFO is already empty here; fetches just wait.
                pend_d = pend_q | fetch;
                if (jmp) tgt_d = jmp_addr;
                if (xfer) begin
                    state_d    = ST_RUN;
                    mem_req_d  = 1'b1;
                    mem_addr_d = jmp ? jmp_addr : tgt_q;
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            mem_req_q  <= 1'b0;
            mem_addr_q <= PC_RST;
            tgt_q      <= PC_RST;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            pc_q       <= PC_RST;
            pend_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            tgt_q      <= tgt_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {mem_addr_q, mem.mem_data};
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign pc           = pc_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count_q == CNT_FULL));

    a_no_refetch: assert property (@(posedge clk) disable iff (rst)
        !(fetch && pend_q));

endmodule
